// File: rtl/write_iq.sv
// write_iq: transmit-side IQ byte writer.
// Pops paired fixed-point I/Q words from two FWFT FIFOs, dequantizes each to a
// signed CHAR_SIZE value and writes it as I_low, I_high, Q_low, Q_high bytes.
// Optional build macro WRITE_IQ_SATURATE_EN: clamp instead of wrap on narrowing.
module write_iq #(
   parameter int DATA_SIZE = 32,
   parameter int BYTE_SIZE = 8,
   parameter int CHAR_SIZE = 16,
   parameter int BITS      = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_SIZE-1:0] i_in,
   input  logic [DATA_SIZE-1:0] q_in,
   input  logic                 i_empty,
   input  logic                 q_empty,
   output logic                 in_rd_en,
   input  logic                 out_full,
   output logic                 out_wr_en,
   output logic [BYTE_SIZE-1:0] data_out,
   output logic [31:0]          pair_count
);

   typedef enum logic [2:0] {
      LOAD,
      WR_I_LOW,
      WR_I_HIGH,
      WR_Q_LOW,
      WR_Q_HIGH
   } state_t;

`ifdef WRITE_IQ_SATURATE_EN
   localparam logic signed [DATA_SIZE-1:0] SAT_MAX =
      {{(DATA_SIZE-CHAR_SIZE+1){1'b0}}, {(CHAR_SIZE-1){1'b1}}};
   localparam logic signed [DATA_SIZE-1:0] SAT_MIN =
      {{(DATA_SIZE-CHAR_SIZE+1){1'b1}}, {(CHAR_SIZE-1){1'b0}}};
`endif

   state_t               state, state_c;
   logic [CHAR_SIZE-1:0] i_sample, q_sample;
   logic [CHAR_SIZE-1:0] i_sample_c, q_sample_c;
   logic [31:0]          pair_count_c;
   logic                 both_ready;

   // Arithmetic shift floors toward negative infinity; narrowing wraps or clamps.
   function automatic logic [CHAR_SIZE-1:0] deq(input logic [DATA_SIZE-1:0] x);
      logic signed [DATA_SIZE-1:0] y;
      y = $signed(x) >>> BITS;
`ifdef WRITE_IQ_SATURATE_EN
      if (y > SAT_MAX)
         return CHAR_SIZE'(SAT_MAX);
      else if (y < SAT_MIN)
         return CHAR_SIZE'(SAT_MIN);
      else
         return CHAR_SIZE'(y);
`else
      return CHAR_SIZE'(y);
`endif
   endfunction

   assign both_ready = !i_empty && !q_empty;

   // Next-state, sample capture and output strobes; nothing is issued while reset is high.
   always_comb begin
      state_c      = state;
      i_sample_c   = i_sample;
      q_sample_c   = q_sample;
      pair_count_c = pair_count;
      in_rd_en     = 1'b0;
      out_wr_en    = 1'b0;
      data_out     = '0;
      if (!reset) begin
         case (state)
            LOAD: begin
               if (both_ready) begin
                  in_rd_en   = 1'b1;
                  i_sample_c = deq(i_in);
                  q_sample_c = deq(q_in);
                  state_c    = WR_I_LOW;
               end
            end
            WR_I_LOW: begin
               if (!out_full) begin
                  out_wr_en = 1'b1;
                  data_out  = i_sample[BYTE_SIZE-1:0];
                  state_c   = WR_I_HIGH;
               end
            end
            WR_I_HIGH: begin
               if (!out_full) begin
                  out_wr_en = 1'b1;
                  data_out  = i_sample[CHAR_SIZE-1:BYTE_SIZE];
                  state_c   = WR_Q_LOW;
               end
            end
            WR_Q_LOW: begin
               if (!out_full) begin
                  out_wr_en = 1'b1;
                  data_out  = q_sample[BYTE_SIZE-1:0];
                  state_c   = WR_Q_HIGH;
               end
            end
            WR_Q_HIGH: begin
               if (!out_full) begin
                  out_wr_en    = 1'b1;
                  data_out     = q_sample[CHAR_SIZE-1:BYTE_SIZE];
                  pair_count_c = pair_count + 32'd1;
                  // Overlapped load: the last byte's cycle also pops the next
                  // pair, so a full FIFO pair streams with no idle cycle.
                  if (both_ready) begin
                     in_rd_en   = 1'b1;
                     i_sample_c = deq(i_in);
                     q_sample_c = deq(q_in);
                     state_c    = WR_I_LOW;
                  end else begin
                     state_c = LOAD;
                  end
               end
            end
            default: state_c = LOAD;
         endcase
      end
   end

   // State, sample and pair-counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= LOAD;
         i_sample   <= '0;
         q_sample   <= '0;
         pair_count <= '0;
      end else begin
         state      <= state_c;
         i_sample   <= i_sample_c;
         q_sample   <= q_sample_c;
         pair_count <= pair_count_c;
      end
   end

endmodule
